// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port backing data memory between the
// data-cache refill engine (port 0), the instruction-cache refill engine
// (port 1) and the store-buffer drain (port 2). Ownership lasts for a whole
// burst, grants are registered, and priority rotates after every grant.
// The owner's command is steered onto the memory bus, read data is broadcast,
// and two saturating counters report contention.
module mem_arbiter #(
   parameter int NUM_PORTS  = 3,
   parameter int STAT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_PORTS-1:0]      req,
   output logic [NUM_PORTS-1:0]      gnt,
   input  logic [NUM_PORTS-1:0]      p_read_en,
   input  logic [NUM_PORTS-1:0]      p_write_en,
   input  logic [32*NUM_PORTS-1:0]   p_addr,
   input  logic [32*NUM_PORTS-1:0]   p_wdata,
   input  logic [4*NUM_PORTS-1:0]    p_byte_en,
   output logic [31:0]               p_rdata,
   output logic                      mem_read_en,
   output logic                      mem_write_en,
   output logic [31:0]               mem_addr,
   output logic [31:0]               mem_wdata,
   output logic [3:0]                mem_byte_en,
   input  logic [31:0]               mem_rdata,
   output logic                      busy,
   output logic [STAT_WIDTH-1:0]     stat_wait_cycles,
   output logic [STAT_WIDTH-1:0]     stat_switches
);

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

   state_t                  state_q, state_d;
   logic [1:0]              owner_q, owner_d;
   logic [1:0]              lastOwner_q, lastOwner_d;
   logic [2:0]              gnt_q, gnt_d;
   logic [STAT_WIDTH-1:0]   waitCnt_q, waitCnt_d;
   logic [STAT_WIDTH-1:0]   switchCnt_q, switchCnt_d;

   logic [2:0]              ownerMask;
   logic [2:0]              otherReqs;
   logic                    ownerActive;
   logic                    switchInc;
   logic                    waitHit;

   // First requesting port in rotating order last+1, last+2, last+3 (mod 3).
   // Scanning from the lowest priority upward lets the highest one win.
   function automatic logic [1:0] pickNext(input logic [2:0] r, input logic [1:0] last);
      logic [1:0] pick;
      logic [1:0] idx;
      pick = 2'd0;
      for (int k = 3; k >= 1; k--) begin
         idx = 2'((int'(last) + k) % 3);
         if (r[idx]) pick = idx;
      end
      return pick;
   endfunction

   assign ownerMask   = 3'b001 << owner_q;
   assign otherReqs   = req & ~ownerMask;
   assign ownerActive = (state_q == OWNED) && req[owner_q];
   assign waitHit     = |(req & ~gnt_q);

   // State, ownership, grant and statistics registers; reset drops the bus at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 2'd0;
         lastOwner_q <= 2'd2;
         gnt_q       <= 3'b000;
         waitCnt_q   <= '0;
         switchCnt_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         lastOwner_q <= lastOwner_d;
         gnt_q       <= gnt_d;
         waitCnt_q   <= waitCnt_d;
         switchCnt_q <= switchCnt_d;
      end
   end

   // Arbitration: grant from idle, hold while the owner requests, and on
   // release hand over to another requester on the same edge if one is waiting.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lastOwner_d = lastOwner_q;
      gnt_d       = gnt_q;
      switchInc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d     = OWNED;
               owner_d     = pickNext(req, lastOwner_q);
               lastOwner_d = pickNext(req, lastOwner_q);
               gnt_d       = 3'b001 << pickNext(req, lastOwner_q);
            end else begin
               gnt_d = 3'b000;
            end
         end
         OWNED: begin
            if (!req[owner_q]) begin
               if (|otherReqs) begin
                  owner_d     = pickNext(otherReqs, owner_q);
                  lastOwner_d = pickNext(otherReqs, owner_q);
                  gnt_d       = 3'b001 << pickNext(otherReqs, owner_q);
                  switchInc   = 1'b1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 3'b000;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 3'b000;
         end
      endcase
   end

   // Saturating contention counters: waiting cycles and back-to-back handovers.
   always_comb begin
      waitCnt_d   = waitCnt_q;
      switchCnt_d = switchCnt_q;
      if (waitHit && (waitCnt_q != STAT_MAX)) waitCnt_d = waitCnt_q + STAT_ONE;
      if (switchInc && (switchCnt_q != STAT_MAX)) switchCnt_d = switchCnt_q + STAT_ONE;
   end

   // Command mux: only an owner that still requests drives the bus; write beats read.
   always_comb begin
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      mem_byte_en  = 4'h0;
      if (ownerActive) begin
         mem_write_en = p_write_en[owner_q];
         mem_read_en  = p_read_en[owner_q] & ~p_write_en[owner_q];
         mem_addr     = p_addr[{owner_q, 5'b00000} +: 32];
         mem_wdata    = p_wdata[{owner_q, 5'b00000} +: 32];
         mem_byte_en  = p_byte_en[{owner_q, 2'b00} +: 4];
      end
   end

   assign gnt              = gnt_q;
   assign busy             = (state_q == OWNED);
   assign p_rdata          = mem_rdata;
   assign stat_wait_cycles = waitCnt_q;
   assign stat_switches    = switchCnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with a queue-based
// scoreboard. Stimulus pushes the expected bus picture for each cycle and a
// monitor pops and compares it shortly after the falling edge.
module tb_mem_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    req;
   logic [2:0]    p_read_en;
   logic [2:0]    p_write_en;
   logic [95:0]   p_addr;
   logic [95:0]   p_wdata;
   logic [11:0]   p_byte_en;
   logic [31:0]   mem_rdata;

   logic [2:0]    gnt;
   logic [31:0]   p_rdata;
   logic          mem_read_en;
   logic          mem_write_en;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_byte_en;
   logic          busy;
   logic [15:0]   stat_wait_cycles;
   logic [15:0]   stat_switches;

   logic [2:0]    gnt4;
   logic [31:0]   p_rdata4;
   logic          mem_read_en4;
   logic          mem_write_en4;
   logic [31:0]   mem_addr4;
   logic [31:0]   mem_wdata4;
   logic [3:0]    mem_byte_en4;
   logic          busy4;
   logic [3:0]    stat_wait_cycles4;
   logic [3:0]    stat_switches4;

   mem_arbiter #(.NUM_PORTS(3), .STAT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .req(req), .gnt(gnt),
      .p_read_en(p_read_en), .p_write_en(p_write_en), .p_addr(p_addr),
      .p_wdata(p_wdata), .p_byte_en(p_byte_en), .p_rdata(p_rdata),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
      .busy(busy), .stat_wait_cycles(stat_wait_cycles), .stat_switches(stat_switches)
   );

   // Narrow-counter instance sharing the same inputs, used for saturation.
   mem_arbiter #(.NUM_PORTS(3), .STAT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .req(req), .gnt(gnt4),
      .p_read_en(p_read_en), .p_write_en(p_write_en), .p_addr(p_addr),
      .p_wdata(p_wdata), .p_byte_en(p_byte_en), .p_rdata(p_rdata4),
      .mem_read_en(mem_read_en4), .mem_write_en(mem_write_en4), .mem_addr(mem_addr4),
      .mem_wdata(mem_wdata4), .mem_byte_en(mem_byte_en4), .mem_rdata(mem_rdata),
      .busy(busy4), .stat_wait_cycles(stat_wait_cycles4), .stat_switches(stat_switches4)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int cycCount = 0;

   // Cycle number used to match expectations to the cycle they describe.
   always @(posedge clk) cycCount++;

   typedef struct {
      string       name;
      int          cyc;
      logic [2:0]  gnt;
      logic        busy;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      int          waitC;
      int          sw;
      int          wait4;
   } expT;

   expT expQ[$];
   int  vecCount  = 0;
   int  missCount = 0;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
      end
   endtask

   // Monitor: pops every expectation due this cycle and compares it to the DUT.
   always @(negedge clk) begin
      #2;
      while (expQ.size() > 0 && expQ[0].cyc <= cycCount) begin
         expT e;
         e = expQ.pop_front();
         if (e.cyc < cycCount) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL %s.stale actual=cycle%0d required=cycle%0d", e.name, cycCount, e.cyc);
         end else begin
            cmp(e.name, "gnt", 32'(gnt), 32'(e.gnt));
            cmp(e.name, "busy", 32'(busy), 32'(e.busy));
            cmp(e.name, "mem_read_en", 32'(mem_read_en), 32'(e.rd));
            cmp(e.name, "mem_write_en", 32'(mem_write_en), 32'(e.wr));
            cmp(e.name, "mem_addr", mem_addr, e.addr);
            cmp(e.name, "mem_wdata", mem_wdata, e.wdata);
            cmp(e.name, "mem_byte_en", 32'(mem_byte_en), 32'(e.be));
            cmp(e.name, "p_rdata", p_rdata, e.rdata);
            if (e.waitC >= 0) cmp(e.name, "stat_wait_cycles", 32'(stat_wait_cycles), 32'(e.waitC));
            if (e.sw >= 0) cmp(e.name, "stat_switches", 32'(stat_switches), 32'(e.sw));
            if (e.wait4 >= 0) cmp(e.name, "stat_wait_cycles_w4", 32'(stat_wait_cycles4), 32'(e.wait4));
         end
      end
   end

   // Moves to the next falling edge and drives reset/req with all port commands cleared.
   task automatic applyStimulus(input logic rst, input logic [2:0] r);
      @(negedge clk);
      reset      = rst;
      req        = r;
      mem_rdata  = 32'hD000_0000 + 32'(cycCount);
      p_read_en  = '0;
      p_write_en = '0;
      p_addr     = '0;
      p_wdata    = '0;
      p_byte_en  = '0;
   endtask

   task automatic setPort(input int p, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
      p_read_en[p]        = rd;
      p_write_en[p]       = wr;
      p_addr[32*p +: 32]  = addr;
      p_wdata[32*p +: 32] = wdata;
      p_byte_en[4*p +: 4] = be;
   endtask

   task automatic checkOutput(input string nm, input logic [2:0] g, input logic b,
                              input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input int waitC, input int sw, input int wait4);
      expT e;
      e.name  = nm;
      e.cyc   = cycCount;
      e.gnt   = g;
      e.busy  = b;
      e.rd    = rd;
      e.wr    = wr;
      e.addr  = addr;
      e.wdata = wdata;
      e.be    = be;
      e.rdata = mem_rdata;
      e.waitC = waitC;
      e.sw    = sw;
      e.wait4 = wait4;
      expQ.push_back(e);
   endtask

   task automatic checkIdle(input string nm, input logic [2:0] g, input logic b,
                            input int waitC, input int sw, input int wait4);
      checkOutput(nm, g, b, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, waitC, sw, wait4);
   endtask

   task automatic threePorts();
      setPort(0, 1'b1, 1'b0, 32'h0000_00A0, 32'h0, 4'hF);
      setPort(1, 1'b1, 1'b0, 32'h0000_00B0, 32'h0, 4'hF);
      setPort(2, 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'hF);
   endtask

   // Directed sequence; each step describes one cycle and its expected bus picture.
   initial begin
      reset      = 1'b1;
      req        = '0;
      p_read_en  = '0;
      p_write_en = '0;
      p_addr     = '0;
      p_wdata    = '0;
      p_byte_en  = '0;
      mem_rdata  = '0;

      // Reset state, first grant and read pass-through
      applyStimulus(1'b1, 3'b000);
      checkIdle("rst", 3'b000, 1'b0, 0, 0, 0);
      applyStimulus(1'b0, 3'b001);
      setPort(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
      checkIdle("t1_pre", 3'b000, 1'b0, 0, 0, -1);
      applyStimulus(1'b0, 3'b001);
      setPort(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
      checkOutput("t1_grant", 3'b001, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1, 0, -1);

      // Read and write together: write wins
      applyStimulus(1'b0, 3'b001);
      setPort(0, 1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 4'b0011);
      checkOutput("t4_wrwins", 3'b001, 1'b1, 1'b0, 1'b1, 32'h104, 32'hCAFE_F00D, 4'b0011, 1, 0, -1);
      applyStimulus(1'b0, 3'b000);
      checkIdle("t1_rel", 3'b001, 1'b1, 1, 0, -1);
      applyStimulus(1'b0, 3'b000);
      checkIdle("t1_idle", 3'b000, 1'b0, 1, 0, -1);
      applyStimulus(1'b0, 3'b000);
      checkIdle("t1_nogrant", 3'b000, 1'b0, 1, 0, -1);

      // Three simultaneous requests: order 0, 1, 2 with back-to-back handovers
      applyStimulus(1'b1, 3'b000);
      checkIdle("t2_rst", 3'b000, 1'b0, 0, 0, 0);
      applyStimulus(1'b0, 3'b111);
      threePorts();
      checkIdle("t2_pre", 3'b000, 1'b0, 0, 0, -1);
      applyStimulus(1'b0, 3'b111);
      threePorts();
      checkOutput("t2_g0", 3'b001, 1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 4'hF, 1, 0, -1);
      applyStimulus(1'b0, 3'b110);
      threePorts();
      checkIdle("t2_rel0", 3'b001, 1'b1, 2, 0, -1);
      applyStimulus(1'b0, 3'b110);
      threePorts();
      checkOutput("t2_g1", 3'b010, 1'b1, 1'b1, 1'b0, 32'hB0, 32'h0, 4'hF, 3, 1, -1);

      // Non-owners writing are ignored
      applyStimulus(1'b0, 3'b110);
      setPort(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'hF);
      setPort(1, 1'b1, 1'b0, 32'h0000_00B0, 32'h0, 4'hF);
      setPort(2, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'hF);
      checkOutput("t3_iso", 3'b010, 1'b1, 1'b1, 1'b0, 32'hB0, 32'h0, 4'hF, 4, 1, -1);
      applyStimulus(1'b0, 3'b100);
      setPort(2, 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'hF);
      checkIdle("t2_rel1", 3'b010, 1'b1, 5, 1, -1);
      applyStimulus(1'b0, 3'b100);
      setPort(2, 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'hF);
      checkOutput("t2_g2", 3'b100, 1'b1, 1'b1, 1'b0, 32'hC0, 32'h0, 4'hF, 6, 2, -1);

      // Asynchronous reset in the middle of a port-2 write burst
      applyStimulus(1'b0, 3'b100);
      setPort(2, 1'b0, 1'b1, 32'h0000_00C4, 32'h1122_3344, 4'hF);
      checkOutput("t6_wr", 3'b100, 1'b1, 1'b0, 1'b1, 32'hC4, 32'h1122_3344, 4'hF, 6, 2, -1);
      applyStimulus(1'b1, 3'b100);
      setPort(2, 1'b0, 1'b1, 32'h0000_00C4, 32'h1122_3344, 4'hF);
      checkIdle("t6_async", 3'b000, 1'b0, 0, 0, 0);
      applyStimulus(1'b0, 3'b100);
      setPort(2, 1'b0, 1'b1, 32'h0000_00C4, 32'h1122_3344, 4'hF);
      checkIdle("t6_rel", 3'b000, 1'b0, 0, 0, -1);
      applyStimulus(1'b0, 3'b100);
      setPort(2, 1'b0, 1'b1, 32'h0000_00C4, 32'h1122_3344, 4'hF);
      checkOutput("t6_regrant", 3'b100, 1'b1, 1'b0, 1'b1, 32'hC4, 32'h1122_3344, 4'hF, 1, 0, -1);
      applyStimulus(1'b0, 3'b000);
      checkIdle("t6_drop", 3'b100, 1'b1, 1, 0, -1);
      applyStimulus(1'b0, 3'b000);
      checkIdle("t6_idle", 3'b000, 1'b0, 1, 0, -1);

      // Port 0 holds while port 2 waits; the 4-bit counter saturates at 15
      applyStimulus(1'b1, 3'b000);
      checkIdle("t5_rst", 3'b000, 1'b0, 0, 0, 0);
      for (int j = 0; j <= 20; j++) begin
         applyStimulus(1'b0, 3'b101);
         setPort(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
         setPort(2, 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'hF);
         if (j == 0) checkIdle($sformatf("t5_wait%0d", j), 3'b000, 1'b0, 0, 0, 0);
         else checkOutput($sformatf("t5_wait%0d", j), 3'b001, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF,
                          j, 0, (j > 15) ? 15 : j);
      end
      applyStimulus(1'b0, 3'b100);
      setPort(2, 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'hF);
      checkIdle("t5_rel0", 3'b001, 1'b1, 21, 0, 15);
      applyStimulus(1'b0, 3'b100);
      setPort(2, 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'hF);
      checkOutput("t5_g2", 3'b100, 1'b1, 1'b1, 1'b0, 32'hC0, 32'h0, 4'hF, 22, 1, 15);
      applyStimulus(1'b0, 3'b000);
      checkIdle("t5_end", 3'b100, 1'b1, 22, 1, 15);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(negedge clk);
         #3;
      end
      if (expQ.size() > 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL drain actual=%0d pending required=0 pending", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
